// File: rtl/cmos_capture_data_pkg.sv
// Shared types and constants for the OV5640 DVP capture block: FSM states, counter widths, RGB565 bars.
package cmos_capture_data_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SKIP = 2'd1,
      RUN  = 2'd2
   } cap_state_t;

   localparam int WAIT_FRAME_DEF = 10;
   localparam int PIX_W_DEF      = 13;
   localparam int SKIP_CNT_W     = 8;

   localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_BLUE    = 16'h001F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = RGB_WHITE;
         3'd1:    c = RGB_YELLOW;
         3'd2:    c = RGB_CYAN;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_MAGENTA;
         3'd5:    c = RGB_RED;
         3'd6:    c = RGB_BLUE;
         default: c = RGB_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cmos_capture_data_if.sv
// DVP sensor pins in, gated RGB565 pixel stream out; slave = capture block, master = sensor/consumer side.
interface cmos_capture_data_if;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        cmos_frame_vsync;
   logic        cmos_frame_href;
   logic        cmos_frame_valid;
   logic [15:0] cmos_frame_data;

   modport master (
      output cam_vsync, cam_href, cam_data,
      input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
   );

   modport slave (
      input  cam_vsync, cam_href, cam_data,
      output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
   );
endinterface

// File: rtl/cmos_capture_data_sync2.sv
// Two-flop synchroniser for a level crossing into the pixel clock domain.
module cmos_capture_data_sync2 (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/cmos_capture_data.sv
// OV5640 DVP byte stream to RGB565 pixel words, with start-up frame skip and line framing checks.
// Define CMOS_TEST_PATTERN_EN to replace the sensor pixels with 8 vertical colour bars.
module cmos_capture_data
   import cmos_capture_data_pkg::*;
#(
   parameter int WAIT_FRAME = WAIT_FRAME_DEF,
   parameter int PIX_W      = PIX_W_DEF
) (
   input  logic               cam_pclk,
   input  logic               rst_n,
   input  logic               capture_start,
   input  logic [PIX_W-1:0]   h_pixel,
   cmos_capture_data_if.slave cam,
   output logic               line_len_err,
   output logic               odd_byte_err
);
   // A frame's own vsync rise also ends the previous frame, so RUN starts on rise WAIT_FRAME+1.
   localparam logic [SKIP_CNT_W-1:0] SKIP_DONE = SKIP_CNT_W'(WAIT_FRAME);

   logic start_s;

   cmos_capture_data_sync2 u_start_sync (
      .clk_i   (cam_pclk),
      .rst_n_i (rst_n),
      .d_i     (capture_start),
      .q_o     (start_s)
   );

   logic        vsync_d0_q, vsync_d1_q;
   logic        href_d0_q, href_d1_q;
   logic [7:0]  data_d0_q;

   cap_state_t              state_q, state_d;
   logic [SKIP_CNT_W-1:0]   skip_cnt_q, skip_cnt_d;
   logic                    err_clr;

   logic                    byte_flag_q, byte_flag_d;
   logic [7:0]              hi_byte_q, hi_byte_d;
   logic                    pix_done_q;
   logic [15:0]             pix_word_q, pix_word_d;
   logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
   logic [PIX_W-1:0]        line_cnt_q, line_cnt_d;
   logic                    line_err_q, line_err_d;
   logic                    odd_err_q, odd_err_d;
   logic                    out_vsync_q, out_vsync_d;
   logic                    out_href_q, out_href_d;
   logic                    out_valid_q, out_valid_d;
   logic [15:0]             out_data_q, out_data_d;

   logic vsync_rise, href_fall, pix_cmp, run_en, check_en;

   assign vsync_rise = vsync_d0_q & ~vsync_d1_q;
   assign href_fall  = ~href_d0_q & href_d1_q;
   assign pix_cmp    = href_d0_q & byte_flag_q;
   assign run_en     = (state_d == RUN);
   assign check_en   = (state_q == RUN) && start_s;

   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      err_clr    = 1'b0;
      if (!start_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = SKIP;
               skip_cnt_d = '0;
               err_clr    = 1'b1;
            end
            SKIP: begin
               if (vsync_rise) begin
                  if (skip_cnt_q == SKIP_DONE) state_d = RUN;
                  else                         skip_cnt_d = skip_cnt_q + 1'b1;
               end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef CMOS_TEST_PATTERN_EN
   logic [PIX_W+2:0] bar_w;
   logic [7:1]       bar_hit;
   logic [2:0]       bar_idx;

   assign bar_w = (PIX_W+3)'(h_pixel >> 3);
   for (genvar gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_hit[gi] = (PIX_W+3)'(pix_cnt_q) >= bar_w * (PIX_W+3)'(gi);
   end

   always_comb begin
      bar_idx = '0;
      for (int i = 1; i < 8; i++) bar_idx = bar_idx + 3'(bar_hit[i]);
   end

   assign pix_word_d = bar_colour(bar_idx);
`else
   assign pix_word_d = {hi_byte_q, data_d0_q};
`endif

   always_comb begin
      byte_flag_d = href_d0_q ? ~byte_flag_q : 1'b0;
      hi_byte_d   = (href_d0_q && !byte_flag_q) ? data_d0_q : hi_byte_q;

      pix_cnt_d = pix_cnt_q;
      if (href_fall)    pix_cnt_d = '0;
      else if (pix_cmp) pix_cnt_d = pix_cnt_q + 1'b1;

      line_cnt_d = line_cnt_q;
      if (vsync_rise)     line_cnt_d = '0;
      else if (href_fall) line_cnt_d = line_cnt_q + 1'b1;

      // An unpaired byte at line end is simply never completed, so it produces no strobe.
      line_err_d = line_err_q;
      odd_err_d  = odd_err_q;
      if (err_clr) begin
         line_err_d = 1'b0;
         odd_err_d  = 1'b0;
      end else if (href_fall && check_en) begin
         if (pix_cnt_q != h_pixel) line_err_d = 1'b1;
         if (byte_flag_q)          odd_err_d  = 1'b1;
      end

      out_vsync_d = vsync_d1_q & run_en;
      out_href_d  = href_d1_q & run_en;
      out_valid_d = pix_done_q & run_en;
      out_data_d  = '0;
      if (run_en) out_data_d = pix_done_q ? pix_word_q : out_data_q;
   end

   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d0_q  <= 1'b0;
         vsync_d1_q  <= 1'b0;
         href_d0_q   <= 1'b0;
         href_d1_q   <= 1'b0;
         data_d0_q   <= '0;
         state_q     <= IDLE;
         skip_cnt_q  <= '0;
         byte_flag_q <= 1'b0;
         hi_byte_q   <= '0;
         pix_done_q  <= 1'b0;
         pix_word_q  <= '0;
         pix_cnt_q   <= '0;
         line_cnt_q  <= '0;
         line_err_q  <= 1'b0;
         odd_err_q   <= 1'b0;
         out_vsync_q <= 1'b0;
         out_href_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         vsync_d0_q  <= cam.cam_vsync;
         vsync_d1_q  <= vsync_d0_q;
         href_d0_q   <= cam.cam_href;
         href_d1_q   <= href_d0_q;
         data_d0_q   <= cam.cam_data;
         state_q     <= state_d;
         skip_cnt_q  <= skip_cnt_d;
         byte_flag_q <= byte_flag_d;
         hi_byte_q   <= hi_byte_d;
         pix_done_q  <= pix_cmp;
         if (pix_cmp) pix_word_q <= pix_word_d;
         pix_cnt_q   <= pix_cnt_d;
         line_cnt_q  <= line_cnt_d;
         line_err_q  <= line_err_d;
         odd_err_q   <= odd_err_d;
         out_vsync_q <= out_vsync_d;
         out_href_q  <= out_href_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign cam.cmos_frame_vsync = out_vsync_q;
   assign cam.cmos_frame_href  = out_href_q;
   assign cam.cmos_frame_valid = out_valid_q;
   assign cam.cmos_frame_data  = out_data_q;
   assign line_len_err         = line_err_q;
   assign odd_byte_err         = odd_err_q;
endmodule
